// File: rtl/ysyx_23060136_wbu_pkg.sv
// Shared types and constants for the write-back stage: FSM states, the
// captured MEM->WB payload, and CSR addresses used by ecall sequences.
package ysyx_23060136_wbu_pkg;

  localparam int WB_BITS_W = 64;
  localparam int WB_INST_W = 32;
  localparam int WB_GPR_W  = 5;
  localparam int WB_CSR_W  = 12;

  localparam logic [WB_CSR_W-1:0] CSR_MEPC   = 12'h341;
  localparam logic [WB_CSR_W-1:0] CSR_MCAUSE = 12'h342;

  typedef enum logic [1:0] {
    WB_RUN    = 2'd0,
    WB_DRAIN  = 2'd1,
    WB_HALTED = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [WB_BITS_W-1:0] pc;
    logic [WB_INST_W-1:0] inst;
    logic                 commit;
    logic [WB_GPR_W-1:0]  rd;
    logic                 write_gpr;
    logic                 mem_to_reg;
    logic [WB_BITS_W-1:0] alu_result;
    logic [WB_BITS_W-1:0] mem_rdata;
    logic                 write_csr_1;
    logic                 write_csr_2;
    logic [WB_CSR_W-1:0]  csr_rd_1;
    logic [WB_CSR_W-1:0]  csr_rd_2;
    logic [WB_BITS_W-1:0] csr_busW_1;
    logic [WB_BITS_W-1:0] csr_busW_2;
    logic                 system_halt;
  } wb_payload_t;

  // Two CSR writes to the same address in one cycle: port 1 takes priority.
  function automatic logic csr_collide(input logic w1, input logic w2,
                                       input logic [WB_CSR_W-1:0] a1,
                                       input logic [WB_CSR_W-1:0] a2);
    return w1 & w2 & (a1 == a2);
  endfunction

endpackage

// File: rtl/ysyx_23060136_wbu_retire_cnt.sv
// 64-bit retired-instruction counter: increments when en is high, wraps
// naturally, and clears synchronously on clr.
module ysyx_23060136_wbu_retire_cnt (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [63:0] count
);

  logic [63:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= 64'd0;
    end else if (en) begin
      count_reg <= count_reg + 64'd1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/ysyx_23060136_wbu_writeback.sv
// Write-back stage: one-cycle register of the MEM instruction driving the
// GPR/CSR write ports, retire tracking, and the RUN/DRAIN/HALTED sequence.
module ysyx_23060136_wbu_writeback
  import ysyx_23060136_wbu_pkg::*;
#(
  parameter int BITS_W = 64,
  parameter int INST_W = 32,
  parameter int GPR_W  = 5,
  parameter int CSR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_i_valid,
  output logic              WB_o_ready,
  input  logic [BITS_W-1:0] MEM_i_pc,
  input  logic [INST_W-1:0] MEM_i_inst,
  input  logic              MEM_i_commit,
  input  logic [GPR_W-1:0]  MEM_i_rd,
  input  logic              MEM_i_write_gpr,
  input  logic              MEM_i_mem_to_reg,
  input  logic [BITS_W-1:0] MEM_i_alu_result,
  input  logic [BITS_W-1:0] MEM_i_mem_rdata,
  input  logic              MEM_i_write_csr_1,
  input  logic              MEM_i_write_csr_2,
  input  logic [CSR_W-1:0]  MEM_i_csr_rd_1,
  input  logic [CSR_W-1:0]  MEM_i_csr_rd_2,
  input  logic [BITS_W-1:0] MEM_i_csr_busW_1,
  input  logic [BITS_W-1:0] MEM_i_csr_busW_2,
  input  logic              MEM_i_system_halt,
  output logic [GPR_W-1:0]  WB_o_rd,
  output logic              WB_o_RegWr,
  output logic [BITS_W-1:0] WB_o_rf_busW,
  output logic [CSR_W-1:0]  WB_o_csr_rd_1,
  output logic [CSR_W-1:0]  WB_o_csr_rd_2,
  output logic              WB_o_CSRWr_1,
  output logic              WB_o_CSRWr_2,
  output logic [BITS_W-1:0] WB_o_csr_busW_1,
  output logic [BITS_W-1:0] WB_o_csr_busW_2,
  output logic              WB_o_valid,
  output logic [BITS_W-1:0] WB_o_pc,
  output logic [INST_W-1:0] WB_o_inst,
  output logic              WB_o_commit,
  output logic [63:0]       WB_o_retire_cnt,
  output logic              WB_o_halt
);

  wb_state_t   state_reg;
  wb_payload_t stage_reg;
  wb_payload_t in_payload;
  logic        valid_reg;
  logic        accept;
  logic        wb_live;
  logic        commit_live;

  always_comb begin
    in_payload             = '0;
    in_payload.pc          = MEM_i_pc;
    in_payload.inst        = MEM_i_inst;
    in_payload.commit      = MEM_i_commit;
    in_payload.rd          = MEM_i_rd;
    in_payload.write_gpr   = MEM_i_write_gpr;
    in_payload.mem_to_reg  = MEM_i_mem_to_reg;
    in_payload.alu_result  = MEM_i_alu_result;
    in_payload.mem_rdata   = MEM_i_mem_rdata;
    in_payload.write_csr_1 = MEM_i_write_csr_1;
    in_payload.write_csr_2 = MEM_i_write_csr_2;
    in_payload.csr_rd_1    = MEM_i_csr_rd_1;
    in_payload.csr_rd_2    = MEM_i_csr_rd_2;
    in_payload.csr_busW_1  = MEM_i_csr_busW_1;
    in_payload.csr_busW_2  = MEM_i_csr_busW_2;
    in_payload.system_halt = MEM_i_system_halt;
  end

  // Ready is masked by rst so nothing is accepted (or advertised) during reset.
  assign WB_o_ready = (state_reg == WB_RUN) & ~rst;
  assign accept     = MEM_i_valid & WB_o_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= WB_RUN;
      valid_reg <= 1'b0;
      stage_reg <= '0;
    end else begin
      valid_reg <= accept;
      if (accept) begin
        stage_reg <= in_payload;
      end
      unique case (state_reg)
        WB_RUN:    if (accept && MEM_i_system_halt) state_reg <= WB_DRAIN;
        WB_DRAIN:  state_reg <= stage_reg.system_halt ? WB_HALTED : WB_RUN;
        WB_HALTED: state_reg <= WB_HALTED;
        default:   state_reg <= WB_RUN;
      endcase
    end
  end

  // An instruction sitting in WB while rst is high is dropped: no strobes reach the register files.
  assign wb_live     = valid_reg & ~rst;
  assign commit_live = wb_live & stage_reg.commit;

  assign WB_o_valid      = wb_live;
  assign WB_o_commit     = commit_live;
  assign WB_o_pc         = stage_reg.pc;
  assign WB_o_inst       = stage_reg.inst;
  assign WB_o_rd         = stage_reg.rd;
  assign WB_o_RegWr      = commit_live & stage_reg.write_gpr & (stage_reg.rd != '0);
  assign WB_o_rf_busW    = stage_reg.mem_to_reg ? stage_reg.mem_rdata : stage_reg.alu_result;
  assign WB_o_csr_rd_1   = stage_reg.csr_rd_1;
  assign WB_o_csr_rd_2   = stage_reg.csr_rd_2;
  assign WB_o_csr_busW_1 = stage_reg.csr_busW_1;
  assign WB_o_csr_busW_2 = stage_reg.csr_busW_2;
  assign WB_o_CSRWr_1    = commit_live & stage_reg.write_csr_1;
  assign WB_o_CSRWr_2    = commit_live & stage_reg.write_csr_2 &
                           ~csr_collide(stage_reg.write_csr_1, stage_reg.write_csr_2,
                                        stage_reg.csr_rd_1, stage_reg.csr_rd_2);
  assign WB_o_halt       = (state_reg == WB_HALTED);

  ysyx_23060136_wbu_retire_cnt u_retire_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (commit_live),
    .count (WB_o_retire_cnt)
  );

endmodule

// File: tb/tb_ysyx_23060136_wbu_writeback.sv
// Directed bench for the write-back stage: handshake, strobe rules, retire
// counting, halt sequence and mid-stream reset.
module tb_ysyx_23060136_wbu_writeback;
  import ysyx_23060136_wbu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_i_valid;
  logic        WB_o_ready;
  logic [63:0] MEM_i_pc;
  logic [31:0] MEM_i_inst;
  logic        MEM_i_commit;
  logic [4:0]  MEM_i_rd;
  logic        MEM_i_write_gpr;
  logic        MEM_i_mem_to_reg;
  logic [63:0] MEM_i_alu_result;
  logic [63:0] MEM_i_mem_rdata;
  logic        MEM_i_write_csr_1;
  logic        MEM_i_write_csr_2;
  logic [11:0] MEM_i_csr_rd_1;
  logic [11:0] MEM_i_csr_rd_2;
  logic [63:0] MEM_i_csr_busW_1;
  logic [63:0] MEM_i_csr_busW_2;
  logic        MEM_i_system_halt;
  logic [4:0]  WB_o_rd;
  logic        WB_o_RegWr;
  logic [63:0] WB_o_rf_busW;
  logic [11:0] WB_o_csr_rd_1;
  logic [11:0] WB_o_csr_rd_2;
  logic        WB_o_CSRWr_1;
  logic        WB_o_CSRWr_2;
  logic [63:0] WB_o_csr_busW_1;
  logic [63:0] WB_o_csr_busW_2;
  logic        WB_o_valid;
  logic [63:0] WB_o_pc;
  logic [31:0] WB_o_inst;
  logic        WB_o_commit;
  logic [63:0] WB_o_retire_cnt;
  logic        WB_o_halt;

  int checks = 0;
  int errors = 0;

  ysyx_23060136_wbu_writeback dut (
    .clk               (clk),
    .rst               (rst),
    .MEM_i_valid       (MEM_i_valid),
    .WB_o_ready        (WB_o_ready),
    .MEM_i_pc          (MEM_i_pc),
    .MEM_i_inst        (MEM_i_inst),
    .MEM_i_commit      (MEM_i_commit),
    .MEM_i_rd          (MEM_i_rd),
    .MEM_i_write_gpr   (MEM_i_write_gpr),
    .MEM_i_mem_to_reg  (MEM_i_mem_to_reg),
    .MEM_i_alu_result  (MEM_i_alu_result),
    .MEM_i_mem_rdata   (MEM_i_mem_rdata),
    .MEM_i_write_csr_1 (MEM_i_write_csr_1),
    .MEM_i_write_csr_2 (MEM_i_write_csr_2),
    .MEM_i_csr_rd_1    (MEM_i_csr_rd_1),
    .MEM_i_csr_rd_2    (MEM_i_csr_rd_2),
    .MEM_i_csr_busW_1  (MEM_i_csr_busW_1),
    .MEM_i_csr_busW_2  (MEM_i_csr_busW_2),
    .MEM_i_system_halt (MEM_i_system_halt),
    .WB_o_rd           (WB_o_rd),
    .WB_o_RegWr        (WB_o_RegWr),
    .WB_o_rf_busW      (WB_o_rf_busW),
    .WB_o_csr_rd_1     (WB_o_csr_rd_1),
    .WB_o_csr_rd_2     (WB_o_csr_rd_2),
    .WB_o_CSRWr_1      (WB_o_CSRWr_1),
    .WB_o_CSRWr_2      (WB_o_CSRWr_2),
    .WB_o_csr_busW_1   (WB_o_csr_busW_1),
    .WB_o_csr_busW_2   (WB_o_csr_busW_2),
    .WB_o_valid        (WB_o_valid),
    .WB_o_pc           (WB_o_pc),
    .WB_o_inst         (WB_o_inst),
    .WB_o_commit       (WB_o_commit),
    .WB_o_retire_cnt   (WB_o_retire_cnt),
    .WB_o_halt         (WB_o_halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MEM_i_valid       = 1'b0;
    MEM_i_pc          = 64'h0;
    MEM_i_inst        = 32'h0;
    MEM_i_commit      = 1'b0;
    MEM_i_rd          = 5'd0;
    MEM_i_write_gpr   = 1'b0;
    MEM_i_mem_to_reg  = 1'b0;
    MEM_i_alu_result  = 64'h0;
    MEM_i_mem_rdata   = 64'h0;
    MEM_i_write_csr_1 = 1'b0;
    MEM_i_write_csr_2 = 1'b0;
    MEM_i_csr_rd_1    = 12'h0;
    MEM_i_csr_rd_2    = 12'h0;
    MEM_i_csr_busW_1  = 64'h0;
    MEM_i_csr_busW_2  = 64'h0;
    MEM_i_system_halt = 1'b0;
  endtask

  task automatic gpr_op(input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] pc);
    idle();
    MEM_i_valid      = 1'b1;
    MEM_i_commit     = 1'b1;
    MEM_i_write_gpr  = 1'b1;
    MEM_i_rd         = rd;
    MEM_i_alu_result = alu;
    MEM_i_pc         = pc;
    MEM_i_inst       = 32'h0000_0033 | {20'h0, rd, 7'h0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    check("reset_valid", 64'(WB_o_valid), 64'd0);
    check("reset_ready", 64'(WB_o_ready), 64'd0);
    check("reset_halt", 64'(WB_o_halt), 64'd0);
    check("reset_regwr", 64'(WB_o_RegWr), 64'd0);
    check("reset_cnt", WB_o_retire_cnt, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(WB_o_ready), 64'd1);

    // Back-to-back ALU ops
    gpr_op(5'd5, 64'h10, 64'h8000_0000);
    step();
    check("b2b1_regwr", 64'(WB_o_RegWr), 64'd1);
    check("b2b1_rd", 64'(WB_o_rd), 64'd5);
    check("b2b1_busw", WB_o_rf_busW, 64'h10);
    check("b2b1_pc", WB_o_pc, 64'h8000_0000);
    check("b2b1_commit", 64'(WB_o_commit), 64'd1);
    gpr_op(5'd6, 64'h20, 64'h8000_0004);
    step();
    check("b2b2_regwr", 64'(WB_o_RegWr), 64'd1);
    check("b2b2_rd", 64'(WB_o_rd), 64'd6);
    check("b2b2_busw", WB_o_rf_busW, 64'h20);
    check("b2b2_cnt", WB_o_retire_cnt, 64'd1);
    idle();
    step();
    check("idle_valid", 64'(WB_o_valid), 64'd0);
    check("idle_regwr", 64'(WB_o_RegWr), 64'd0);
    check("b2b_cnt", WB_o_retire_cnt, 64'd2);

    // Load, then a non-committed bubble
    gpr_op(5'd7, 64'h8000_0000, 64'h8000_0008);
    MEM_i_mem_to_reg = 1'b1;
    MEM_i_mem_rdata  = 64'hFFFF_FFFF_FFFF_FF80;
    step();
    check("load_regwr", 64'(WB_o_RegWr), 64'd1);
    check("load_busw", WB_o_rf_busW, 64'hFFFF_FFFF_FFFF_FF80);
    gpr_op(5'd8, 64'h55, 64'h8000_000C);
    MEM_i_commit = 1'b0;
    step();
    check("bubble_valid", 64'(WB_o_valid), 64'd1);
    check("bubble_regwr", 64'(WB_o_RegWr), 64'd0);
    check("bubble_commit", 64'(WB_o_commit), 64'd0);
    check("load_cnt", WB_o_retire_cnt, 64'd3);

    // rd=0 suppression
    gpr_op(5'd0, 64'h1234, 64'h8000_0010);
    step();
    check("rd0_regwr", 64'(WB_o_RegWr), 64'd0);
    check("rd0_commit", 64'(WB_o_commit), 64'd1);
    check("rd0_busw", WB_o_rf_busW, 64'h1234);
    check("bubble_cnt", WB_o_retire_cnt, 64'd3);

    // ecall: dual CSR write, then same-address collision
    idle();
    MEM_i_valid       = 1'b1;
    MEM_i_commit      = 1'b1;
    MEM_i_write_csr_1 = 1'b1;
    MEM_i_write_csr_2 = 1'b1;
    MEM_i_csr_rd_1    = CSR_MEPC;
    MEM_i_csr_rd_2    = CSR_MCAUSE;
    MEM_i_csr_busW_1  = 64'h8000_0100;
    MEM_i_csr_busW_2  = 64'd11;
    step();
    check("ecall_csrwr1", 64'(WB_o_CSRWr_1), 64'd1);
    check("ecall_csrwr2", 64'(WB_o_CSRWr_2), 64'd1);
    check("ecall_addr1", 64'(WB_o_csr_rd_1), 64'h341);
    check("ecall_addr2", 64'(WB_o_csr_rd_2), 64'h342);
    check("ecall_data1", WB_o_csr_busW_1, 64'h8000_0100);
    check("ecall_data2", WB_o_csr_busW_2, 64'd11);
    check("ecall_regwr", 64'(WB_o_RegWr), 64'd0);
    MEM_i_csr_rd_2 = CSR_MEPC;
    step();
    check("collide_csrwr1", 64'(WB_o_CSRWr_1), 64'd1);
    check("collide_csrwr2", 64'(WB_o_CSRWr_2), 64'd0);
    check("ecall_cnt", WB_o_retire_cnt, 64'd5);
    idle();
    step();
    check("idle2_csrwr1", 64'(WB_o_CSRWr_1), 64'd0);
    check("idle2_cnt", WB_o_retire_cnt, 64'd6);

    // Halt sequence
    gpr_op(5'd9, 64'h99, 64'h8000_0020);
    MEM_i_inst        = 32'h0010_0073;
    MEM_i_system_halt = 1'b1;
    check("pre_halt_ready", 64'(WB_o_ready), 64'd1);
    step();
    check("drain_regwr", 64'(WB_o_RegWr), 64'd1);
    check("drain_commit", 64'(WB_o_commit), 64'd1);
    check("drain_inst", 64'(WB_o_inst), 64'h0010_0073);
    check("drain_ready", 64'(WB_o_ready), 64'd0);
    check("drain_halt", 64'(WB_o_halt), 64'd0);
    gpr_op(5'd10, 64'hAA, 64'h8000_0024);
    MEM_i_write_csr_1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halted_halt", 64'(WB_o_halt), 64'd1);
      check("halted_ready", 64'(WB_o_ready), 64'd0);
      check("halted_valid", 64'(WB_o_valid), 64'd0);
      check("halted_regwr", 64'(WB_o_RegWr), 64'd0);
      check("halted_csrwr1", 64'(WB_o_CSRWr_1), 64'd0);
      check("halted_cnt", WB_o_retire_cnt, 64'd7);
    end

    // Reset mid-stream with an instruction in WB and retire_cnt=7
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      gpr_op(5'(i), 64'(i * 3), 64'h8000_1000 + 64'(i * 4));
      step();
    end
    check("pre_rst_cnt", WB_o_retire_cnt, 64'd7);
    check("pre_rst_regwr", 64'(WB_o_RegWr), 64'd1);
    check("pre_rst_busw", WB_o_rf_busW, 64'd24);
    rst = 1'b1;
    #1;
    check("in_rst_regwr", 64'(WB_o_RegWr), 64'd0);
    check("in_rst_commit", 64'(WB_o_commit), 64'd0);
    step();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_regwr", 64'(WB_o_RegWr), 64'd0);
    check("post_rst_valid", 64'(WB_o_valid), 64'd0);
    check("post_rst_cnt", WB_o_retire_cnt, 64'd0);
    check("post_rst_halt", 64'(WB_o_halt), 64'd0);
    check("post_rst_ready", 64'(WB_o_ready), 64'd1);
    gpr_op(5'd3, 64'h77, 64'h8000_2000);
    step();
    check("run_again_regwr", 64'(WB_o_RegWr), 64'd1);
    check("run_again_busw", WB_o_rf_busW, 64'h77);
    idle();
    step();
    check("run_again_cnt", WB_o_retire_cnt, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
